// File: rtl/msg_sequencer.sv
// msg_sequencer: steps a 3-bit character code through "HELLO " for a 7-segment decoder.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   start - level; begin from IDLE or resume from HOLD
//   stop  - level; pause from RUN or abort from HOLD (wins over start)
//   key   - character code: 000=H 001=E 010=L 011=O 111=blank
//   pos   - message index 0..5
//   busy  - high in RUN and HOLD
//   wrap  - one-cycle pulse after pos leaves 5
//
// Optional: define MSG_SEQUENCER_BLINK_EN to blink key in HOLD using a
// separate blink counter, leaving the main prescaler frozen.
module msg_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int LOOP     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    output logic [2:0] key,
    output logic [2:0] pos,
    output logic       busy,
    output logic       wrap
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    pos_n, key_n;
    logic          busy_n, wrap_n, tick;

    function automatic logic [2:0] rom(input logic [2:0] p);
        return p == 3'd0 ? 3'b000 :
               p == 3'd1 ? 3'b001 :
               p <= 3'd3 ? 3'b010 :
               p == 3'd4 ? 3'b011 : 3'b111;
    endfunction

`ifdef MSG_SEQUENCER_BLINK_EN
    logic [CW-1:0] bcnt, bcnt_n;
    logic          blank, blank_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pos   <= 3'd0;
            key   <= 3'b111;
            busy  <= 1'b0;
            wrap  <= 1'b0;
`ifdef MSG_SEQUENCER_BLINK_EN
            bcnt  <= '0;
            blank <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pos   <= pos_n;
            key   <= key_n;
            busy  <= busy_n;
            wrap  <= wrap_n;
`ifdef MSG_SEQUENCER_BLINK_EN
            bcnt  <= bcnt_n;
            blank <= blank_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pos_n   = pos;
        wrap_n  = 1'b0;
        tick    = state == RUN && cnt == LAST;
        case (state)
            IDLE: begin
                cnt_n = '0;
                pos_n = 3'd0;
                if (start && !stop) state_n = RUN;
            end
            RUN: begin
                // stop takes priority over a coincident tick: the step is dropped
                if (stop) state_n = HOLD;
                else if (tick) begin
                    cnt_n = '0;
                    if (pos == 3'd5) begin
                        wrap_n = 1'b1;
                        pos_n  = 3'd0;
                        if (LOOP == 0) state_n = IDLE;
                    end else pos_n = pos + 3'd1;
                end else cnt_n = cnt + 1'b1;
            end
            HOLD: begin
                if (stop) begin
                    state_n = IDLE;
                    pos_n   = 3'd0;
                    cnt_n   = '0;
                end else if (start) state_n = RUN;
            end
            default: begin
                state_n = IDLE;
                pos_n   = 3'd0;
                cnt_n   = '0;
            end
        endcase
        busy_n = state_n == RUN || state_n == HOLD;
        key_n  = state_n == IDLE ? 3'b111 : rom(pos_n);
`ifdef MSG_SEQUENCER_BLINK_EN
        // blink phase restarts on HOLD entry so the character shows first
        bcnt_n  = '0;
        blank_n = 1'b0;
        if (state == HOLD && state_n == HOLD) begin
            bcnt_n  = bcnt == LAST ? '0 : bcnt + 1'b1;
            blank_n = bcnt == LAST ? !blank : blank;
        end
        if (blank_n) key_n = 3'b111;
`endif
    end
endmodule
